// File: rtl/gf_mult_seq.sv
// Bit-serial GF(2^M) multiplier: one bit of B per cycle, LSB first, reduced by POLY.
// Optional early termination when the remaining B bits are zero: define GF_MULT_ZERO_SKIP_EN.
module gf_mult_seq #(
   parameter int          M    = 8,
   parameter logic [15:0] POLY = 16'h001D
) (
   input  logic         CK,
   input  logic         RN,
   input  logic         START,
   input  logic [M-1:0] A,
   input  logic [M-1:0] B,
   output logic         READY,
   output logic         BUSY,
   output logic         DONE,
   output logic [M-1:0] Y,
   output logic [1:0]   state_dbg
);

   localparam int          CNT_W  = $clog2(M + 1);
   localparam logic [M-1:0] POLY_M = POLY[M-1:0];

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      FIN  = 2'd2
   } state_t;

   state_t             state_q, state_d;
   logic [M-1:0]       a_q, a_d;
   logic [M-1:0]       b_q, b_d;
   logic [M-1:0]       acc_q, acc_d;
   logic [M-1:0]       y_q, y_d;
   logic [CNT_W-1:0]   cnt_q, cnt_d;
   logic [M-1:0]       acc_next;
   logic [M-1:0]       a_xtime;
   logic [M-1:0]       b_shift;
   logic               run_last;

   // Datapath step for one RUN edge: accumulate, multiply a by x, consume one bit of b.
   always_comb begin
      acc_next = acc_q ^ (b_q[0] ? a_q : '0);
      a_xtime  = {a_q[M-2:0], 1'b0} ^ (a_q[M-1] ? POLY_M : '0);
      b_shift  = b_q >> 1;
`ifdef GF_MULT_ZERO_SKIP_EN
      run_last = (cnt_q == CNT_W'(1)) || (b_shift == '0);
`else
      run_last = (cnt_q == CNT_W'(1));
`endif
   end

   always_comb begin
      state_d = state_q;
      a_d     = a_q;
      b_d     = b_q;
      acc_d   = acc_q;
      y_d     = y_q;
      cnt_d   = cnt_q;
      unique case (state_q)
         IDLE: begin
            if (START) begin
               a_d     = A;
               b_d     = B;
               acc_d   = '0;
               cnt_d   = CNT_W'(M);
               state_d = RUN;
            end
         end
         RUN: begin
            acc_d = acc_next;
            a_d   = a_xtime;
            b_d   = b_shift;
            cnt_d = cnt_q - CNT_W'(1);
            if (run_last) begin
               y_d     = acc_next;
               state_d = FIN;
            end
         end
         FIN: begin
            state_d = IDLE;
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   always_ff @(posedge CK or negedge RN) begin
      if (!RN) begin
         state_q <= IDLE;
         a_q     <= '0;
         b_q     <= '0;
         acc_q   <= '0;
         y_q     <= '0;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         a_q     <= a_d;
         b_q     <= b_d;
         acc_q   <= acc_d;
         y_q     <= y_d;
         cnt_q   <= cnt_d;
      end
   end

   // Handshake: START is taken on a rising edge only while READY is high; DONE marks
   // the single cycle in which Y first shows a new product. All outputs come from flops.
   assign READY     = (state_q == IDLE);
   assign BUSY      = (state_q == RUN);
   assign DONE      = (state_q == FIN);
   assign Y         = y_q;
   assign state_dbg = state_q;

endmodule

// File: tb/tb_gf_mult_seq.sv
// Bench for gf_mult_seq: three instances (default field, AES field, M=4) checked against
// a carry-less-multiply-then-reduce reference model.
module tb_gf_mult_seq;

   logic       clk;
   logic       rst_n;
   logic [2:0] start;
   logic [7:0] a_in [3];
   logic [7:0] b_in [3];
   logic [2:0] ready;
   logic [2:0] busy;
   logic [2:0] done;
   logic [7:0] y_out [3];
   logic [3:0] y_m4;
   logic [1:0] dbg [3];

   int n_vec;
   int n_err;

   localparam logic [15:0] POLY_K [3] = '{16'h001D, 16'h001B, 16'h0003};
   localparam int          M_K    [3] = '{8, 8, 4};

   gf_mult_seq #(.M(8), .POLY(16'h001D)) u_def (
      .CK(clk), .RN(rst_n), .START(start[0]), .A(a_in[0]), .B(b_in[0]),
      .READY(ready[0]), .BUSY(busy[0]), .DONE(done[0]), .Y(y_out[0]), .state_dbg(dbg[0]));

   gf_mult_seq #(.M(8), .POLY(16'h001B)) u_aes (
      .CK(clk), .RN(rst_n), .START(start[1]), .A(a_in[1]), .B(b_in[1]),
      .READY(ready[1]), .BUSY(busy[1]), .DONE(done[1]), .Y(y_out[1]), .state_dbg(dbg[1]));

   gf_mult_seq #(.M(4), .POLY(16'h0003)) u_m4 (
      .CK(clk), .RN(rst_n), .START(start[2]), .A(a_in[2][3:0]), .B(b_in[2][3:0]),
      .READY(ready[2]), .BUSY(busy[2]), .DONE(done[2]), .Y(y_m4), .state_dbg(dbg[2]));

   always_comb y_out[2] = {4'h0, y_m4};

   // clock / reset
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // Reference: plain polynomial product, then long division by x^m + poly.
   function automatic logic [15:0] gf_ref(input int m, input logic [15:0] poly,
                                          input logic [15:0] a, input logic [15:0] b);
      logic [31:0] p;
      logic [31:0] full;
      logic [15:0] mask;
      mask = 16'((32'h1 << m) - 1);
      p    = '0;
      full = {16'h0, poly & mask} | (32'h1 << m);
      for (int i = 0; i < m; i++)
         if (b[i] & mask[i]) p = p ^ ({16'h0, a & mask} << i);
      for (int i = 2 * m - 2; i >= m; i--)
         if (p[i]) p = p ^ (full << (i - m));
      return p[15:0];
   endfunction

   function automatic int exp_lat(input int k, input logic [7:0] b);
`ifdef GF_MULT_ZERO_SKIP_EN
      int hi;
      hi = 0;
      for (int i = 0; i < M_K[k]; i++)
         if (b[i]) hi = i + 1;
      return (hi < 1) ? 1 : hi;
`else
      return (b === 8'hxx) ? 0 : M_K[k];
`endif
   endfunction

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_vec++;
      assert (obs === exp)
      else begin
         n_err++;
         $error("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
      end
   endtask

   task automatic drive(input int k, input logic s, input logic [7:0] a, input logic [7:0] b);
      start[k] = s;
      a_in[k]  = a;
      b_in[k]  = b;
   endtask

   // One full operation on instance k with latency, result and handshake checks.
   task automatic run_op(input int k, input logic [7:0] a, input logic [7:0] b);
      int n;
      logic [7:0] mask;
      mask = 8'((32'h1 << M_K[k]) - 1);
      @(negedge clk);
      drive(k, 1'b1, a, b);
      @(posedge clk);
      #1;
      drive(k, 1'b0, 8'($urandom), 8'($urandom));
      check($sformatf("busy_after_accept[%0d]", k), {31'h0, busy[k]}, 32'h1);
      check($sformatf("ready_low_in_run[%0d]", k), {31'h0, ready[k]}, 32'h0);
      n = 0;
      while (n < 40) begin
         @(posedge clk);
         #1;
         n++;
         if (done[k]) break;
      end
      check($sformatf("latency[%0d] a=%0h b=%0h", k, a, b), n, exp_lat(k, b & mask));
      check($sformatf("y[%0d] a=%0h b=%0h", k, a, b), {24'h0, y_out[k]},
            {16'h0, gf_ref(M_K[k], POLY_K[k], {8'h0, a}, {8'h0, b})});
      @(posedge clk);
      #1;
      check($sformatf("ready_after_done[%0d]", k), {31'h0, ready[k]}, 32'h1);
      check($sformatf("done_one_cycle[%0d]", k), {31'h0, done[k]}, 32'h0);
   endtask

   initial begin
      int cnt;
      int last;
      int per;
      int exp_cnt;
      logic [7:0] ra;
      logic [7:0] rb;
      n_vec = 0;
      n_err = 0;
      rst_n = 1'b0;
      for (int k = 0; k < 3; k++) drive(k, 1'b0, 8'h00, 8'h00);
      #2;
      for (int k = 0; k < 3; k++) begin
         check($sformatf("rst_ready[%0d]", k), {31'h0, ready[k]}, 32'h1);
         check($sformatf("rst_busy[%0d]", k), {31'h0, busy[k]}, 32'h0);
         check($sformatf("rst_done[%0d]", k), {31'h0, done[k]}, 32'h0);
         check($sformatf("rst_y[%0d]", k), {24'h0, y_out[k]}, 32'h0);
      end
      @(negedge clk);
      @(negedge clk);
      rst_n = 1'b1;

      // Directed vectors
      run_op(0, 8'h02, 8'h80);
      run_op(0, 8'hA7, 8'h01);
      run_op(0, 8'h00, 8'h5A);
      run_op(0, 8'h5A, 8'h00);
      run_op(1, 8'h53, 8'hCA);
      run_op(1, 8'h57, 8'h83);
      run_op(2, 8'h08, 8'h02);
      run_op(2, 8'h0F, 8'h0F);
      run_op(0, 8'h03, 8'h03);

      // Randomised vectors on every instance
      for (int i = 0; i < 20; i++)
         for (int k = 0; k < 3; k++) begin
            ra = 8'($urandom_range(0, 255));
            rb = 8'($urandom_range(0, 255));
            run_op(k, ra, rb);
         end

      // START during RUN is ignored
      @(negedge clk);
      drive(0, 1'b1, 8'h02, 8'h80);
      @(posedge clk);
      #1;
      drive(0, 1'b0, 8'h00, 8'h00);
      repeat (2) @(posedge clk);
      @(negedge clk);
      if (busy[0]) drive(0, 1'b1, 8'hFF, 8'hFF);
      @(negedge clk);
      drive(0, 1'b0, 8'h00, 8'h00);
      cnt = 0;
      for (int i = 0; i < 20; i++) begin
         @(posedge clk);
         #1;
         if (done[0]) begin
            cnt++;
            check("y_ignore_start", {24'h0, y_out[0]}, 32'h1D);
         end
      end
      check("done_count_ignore_start", cnt, 1);

      // START held high: one result per latency+2 cycles
      per = exp_lat(0, 8'h03) + 2;
      @(negedge clk);
      drive(0, 1'b1, 8'h03, 8'h03);
      cnt = 0;
      last = 0;
      exp_cnt = 0;
      for (int e = 1; e <= 30; e++) begin
         @(posedge clk);
         #1;
         if (((e - 1 - exp_lat(0, 8'h03)) % per == 0) && (e > exp_lat(0, 8'h03))) exp_cnt++;
         if (done[0]) begin
            check("y_back_to_back", {24'h0, y_out[0]}, 32'h05);
            if (cnt > 0) check("done_spacing", e - last, per);
            cnt++;
            last = e;
         end
      end
      check("done_count_held_start", cnt, exp_cnt);
      @(negedge clk);
      drive(0, 1'b0, 8'h00, 8'h00);
      repeat (per + 1) @(posedge clk);
      #1;
      check("idle_after_held_start", {31'h0, ready[0]}, 32'h1);

      // Reset mid-RUN aborts with no DONE
      @(negedge clk);
      drive(0, 1'b1, 8'h57, 8'h83);
      @(posedge clk);
      #1;
      drive(0, 1'b0, 8'h00, 8'h00);
      repeat (3) @(posedge clk);
      #3;
      rst_n = 1'b0;
      #1;
      check("midrun_rst_ready", {31'h0, ready[0]}, 32'h1);
      check("midrun_rst_busy", {31'h0, busy[0]}, 32'h0);
      check("midrun_rst_done", {31'h0, done[0]}, 32'h0);
      check("midrun_rst_y", {24'h0, y_out[0]}, 32'h0);
      @(negedge clk);
      rst_n = 1'b1;
      cnt = 0;
      for (int i = 0; i < 12; i++) begin
         @(posedge clk);
         #1;
         if (done[0]) cnt++;
      end
      check("no_done_after_abort", cnt, 0);
      run_op(0, 8'h57, 8'h83);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

   // Global time limit so the run always ends
   initial begin
      #200000;
      $display("FAIL timeout: simulation did not finish, expected completion");
      $fatal(1, "timeout");
   end

endmodule
